// File: rtl/triadic_alu_issue_scheduler_pkg.sv
// Constants shared between the Triadic ALU and its issue scheduler.
// The scheduler's tag pipeline depth has to match the ALU pipeline depth, so both take it from here.
package triadic_alu_issue_scheduler_pkg;

    localparam int TRIADIC_ALU_CTRL_WIDTH = 20;
    localparam int TRIADIC_ALU_LATENCY    = 4;

    localparam logic [TRIADIC_ALU_CTRL_WIDTH-1:0] ALU_CTRL_NOP = '0;

endpackage

// File: rtl/triadic_alu_issue_scheduler_arbiter.sv
// Round-robin arbiter that issues a one-hot grant.
// The search begins at the requester after the most recent grant.
module triadic_alu_issue_scheduler_arbiter #(
    parameter int REQUESTER_COUNT = 4,
    parameter int ID_WIDTH        = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [REQUESTER_COUNT-1:0] request,
    output logic [REQUESTER_COUNT-1:0] grant,
    output logic                       grant_valid,
    output logic [ID_WIDTH-1:0]        grant_id
);

    logic [ID_WIDTH-1:0] start_ptr;
    logic [ID_WIDTH-1:0] idx;

    // NOTE: combinational logic uses '=' and assigns every output a default first, so no latch is inferred.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int k = 0; k < REQUESTER_COUNT; k++) begin
            idx = ID_WIDTH'((int'(start_ptr) + k) % REQUESTER_COUNT);
            if (!grant_valid && request[idx]) begin
                grant_valid = 1'b1;
                grant_id    = idx;
            end
        end
        if (grant_valid) begin
            grant[grant_id] = 1'b1;
        end
    end

    // NOTE: registered state uses '<=' so that every flop samples values from before the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_ptr <= '0;
        end else if (grant_valid) begin
            start_ptr <= ID_WIDTH'((int'(grant_id) + 1) % REQUESTER_COUNT);
        end
    end

endmodule

// File: rtl/triadic_alu_issue_scheduler.sv
// Shares one Triadic ALU among several requesters. Each op is tagged through the fixed ALU latency,
// and the result goes back to the requester that issued it, together with that requester's R and S contexts.
module triadic_alu_issue_scheduler
    import triadic_alu_issue_scheduler_pkg::*;
#(
    parameter int WORD_WIDTH      = 36,
    parameter int REQUESTER_COUNT = 4,
    parameter int ID_WIDTH        = 2,
    parameter int ALU_LATENCY     = TRIADIC_ALU_LATENCY
) (
    input  logic                                              clock,
    input  logic                                              reset,
    input  logic [REQUESTER_COUNT-1:0]                        req_valid,
    output logic [REQUESTER_COUNT-1:0]                        req_ready,
    input  logic [REQUESTER_COUNT*TRIADIC_ALU_CTRL_WIDTH-1:0] req_control,
    input  logic [REQUESTER_COUNT*WORD_WIDTH-1:0]             req_A,
    input  logic [REQUESTER_COUNT*WORD_WIDTH-1:0]             req_B,
    input  logic                                              s_write,
    input  logic [ID_WIDTH-1:0]                               s_id,
    input  logic [WORD_WIDTH-1:0]                             s_data,
    output logic [TRIADIC_ALU_CTRL_WIDTH-1:0]                 alu_control,
    output logic [WORD_WIDTH-1:0]                             alu_A,
    output logic [WORD_WIDTH-1:0]                             alu_B,
    output logic [WORD_WIDTH-1:0]                             alu_R,
    output logic [WORD_WIDTH-1:0]                             alu_S,
    output logic                                              alu_R_zero,
    output logic                                              alu_R_negative,
    input  logic [WORD_WIDTH-1:0]                             alu_Ra,
    input  logic [WORD_WIDTH-1:0]                             alu_Rb,
    input  logic                                              alu_carry_out,
    input  logic                                              alu_overflow,
    output logic                                              rsp_valid,
    output logic [ID_WIDTH-1:0]                               rsp_id,
    output logic [WORD_WIDTH-1:0]                             rsp_Ra,
    output logic [WORD_WIDTH-1:0]                             rsp_Rb,
    output logic                                              rsp_carry_out,
    output logic                                              rsp_overflow
);

    localparam int CW = TRIADIC_ALU_CTRL_WIDTH;

    typedef struct packed {
        logic                valid;
        logic [ID_WIDTH-1:0] id;
    } issue_tag_t;

    issue_tag_t                 tag_pipe [ALU_LATENCY];
    issue_tag_t                 retire_tag;
    logic [REQUESTER_COUNT-1:0] pending;
    logic [REQUESTER_COUNT-1:0] retire_hit;
    logic [REQUESTER_COUNT-1:0] eligible;
    logic [REQUESTER_COUNT-1:0] grant;
    logic                       grant_valid;
    logic [ID_WIDTH-1:0]        grant_id;
    logic [WORD_WIDTH-1:0]      r_ctx [REQUESTER_COUNT];
    logic [WORD_WIDTH-1:0]      s_ctx [REQUESTER_COUNT];

    assign retire_tag = tag_pipe[ALU_LATENCY-1];

    always_comb begin
        retire_hit = '0;
        if (retire_tag.valid) begin
            retire_hit[retire_tag.id] = 1'b1;
        end
    end

    // A requester whose result retires this cycle is eligible again right away, with its new R bypassed in.
    assign eligible = req_valid & (~pending | retire_hit) & {REQUESTER_COUNT{~reset}};

    triadic_alu_issue_scheduler_arbiter #(
        .REQUESTER_COUNT(REQUESTER_COUNT),
        .ID_WIDTH       (ID_WIDTH)
    ) u_arbiter (
        .clock      (clock),
        .reset      (reset),
        .request    (eligible),
        .grant      (grant),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    assign req_ready = grant;

    always_comb begin
        alu_control = ALU_CTRL_NOP;
        alu_A       = '0;
        alu_B       = '0;
        alu_R       = '0;
        alu_S       = '0;
        if (grant_valid) begin
            alu_control = req_control[int'(grant_id)*CW +: CW];
            alu_A       = req_A[int'(grant_id)*WORD_WIDTH +: WORD_WIDTH];
            alu_B       = req_B[int'(grant_id)*WORD_WIDTH +: WORD_WIDTH];
            alu_R       = retire_hit[grant_id] ? alu_Ra : r_ctx[grant_id];
            alu_S       = s_ctx[grant_id];
        end
    end

    assign alu_R_zero     = (alu_R == '0);
    assign alu_R_negative = alu_R[WORD_WIDTH-1];

    assign rsp_valid     = retire_tag.valid;
    assign rsp_id        = retire_tag.id;
    assign rsp_Ra        = alu_Ra;
    assign rsp_Rb        = alu_Rb;
    assign rsp_carry_out = alu_carry_out;
    assign rsp_overflow  = alu_overflow;

    // If the same requester retires and issues in one cycle, the new pending bit has priority over the clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
            for (int i = 0; i < ALU_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            pending     <= (pending & ~retire_hit) | grant;
            tag_pipe[0] <= '{valid: grant_valid, id: (grant_valid ? grant_id : '0)};
            for (int i = 1; i < ALU_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // NOTE: the contexts are discrete flops rather than a RAM, so they can take the async clear like any other state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REQUESTER_COUNT; i++) begin
                r_ctx[i] <= '0;
                s_ctx[i] <= '0;
            end
        end else begin
            if (retire_tag.valid) begin
                r_ctx[retire_tag.id] <= alu_Ra;
            end
            if (s_write && (int'(s_id) < REQUESTER_COUNT)) begin
                s_ctx[s_id] <= s_data;
            end
        end
    end

endmodule

// File: tb/tb_triadic_alu_issue_scheduler.sv
// Directed bench for triadic_alu_issue_scheduler. A small 4-stage ALU model sits behind the scheduler
// (Ra=A+B, Rb=A^B, carry and signed overflow of the add).
module tb_triadic_alu_issue_scheduler;
    import triadic_alu_issue_scheduler_pkg::*;

    localparam int W   = 36;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int CW  = TRIADIC_ALU_CTRL_WIDTH;
    localparam int LAT = TRIADIC_ALU_LATENCY;
    localparam logic [CW-1:0] ADD = 20'h00001;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*CW-1:0] req_control;
    logic [N*W-1:0]  req_A, req_B;
    logic            s_write;
    logic [IDW-1:0]  s_id;
    logic [W-1:0]    s_data;
    logic [CW-1:0]   alu_control;
    logic [W-1:0]    alu_A, alu_B, alu_R, alu_S;
    logic            alu_R_zero, alu_R_negative;
    logic [W-1:0]    alu_Ra, alu_Rb;
    logic            alu_carry_out, alu_overflow;
    logic            rsp_valid;
    logic [IDW-1:0]  rsp_id;
    logic [W-1:0]    rsp_Ra, rsp_Rb;
    logic            rsp_carry_out, rsp_overflow;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    triadic_alu_issue_scheduler #(
        .WORD_WIDTH(W), .REQUESTER_COUNT(N), .ID_WIDTH(IDW), .ALU_LATENCY(LAT)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_control(req_control),
        .req_A(req_A), .req_B(req_B),
        .s_write(s_write), .s_id(s_id), .s_data(s_data),
        .alu_control(alu_control), .alu_A(alu_A), .alu_B(alu_B), .alu_R(alu_R), .alu_S(alu_S),
        .alu_R_zero(alu_R_zero), .alu_R_negative(alu_R_negative),
        .alu_Ra(alu_Ra), .alu_Rb(alu_Rb), .alu_carry_out(alu_carry_out), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_Ra(rsp_Ra), .rsp_Rb(rsp_Rb),
        .rsp_carry_out(rsp_carry_out), .rsp_overflow(rsp_overflow)
    );

    // ALU model: a fixed pipeline with no reset
    logic [W:0]   m_sum;
    logic [W-1:0] m_ra [LAT];
    logic [W-1:0] m_rb [LAT];
    logic         m_c  [LAT];
    logic         m_v  [LAT];
    assign m_sum = {1'b0, alu_A} + {1'b0, alu_B};
    always @(posedge clock) begin
        m_ra[0] <= m_sum[W-1:0];
        m_rb[0] <= alu_A ^ alu_B;
        m_c[0]  <= m_sum[W];
        m_v[0]  <= (alu_A[W-1] == alu_B[W-1]) && (m_sum[W-1] != alu_A[W-1]);
        for (int i = 1; i < LAT; i++) begin
            m_ra[i] <= m_ra[i-1];
            m_rb[i] <= m_rb[i-1];
            m_c[i]  <= m_c[i-1];
            m_v[i]  <= m_v[i-1];
        end
    end
    assign alu_Ra        = m_ra[LAT-1];
    assign alu_Rb        = m_rb[LAT-1];
    assign alu_carry_out = m_c[LAT-1];
    assign alu_overflow  = m_v[LAT-1];

    // Each cycle: inputs are driven 1ns after the rising edge and outputs are checked 4ns later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid   = '0;
        req_control = '0;
        req_A       = '0;
        req_B       = '0;
        s_write     = 1'b0;
        s_id        = '0;
        s_data      = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [CW-1:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[i]           = 1'b1;
        req_control[i*CW +: CW] = ctrl;
        req_A[i*W +: W]         = a;
        req_B[i*W +: W]         = b;
    endtask

    task automatic test_reset();
        int bad;
        clear_inputs();
        reset = 1'b1;
        #4;
        total++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready); else passed++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else passed++;
        total++; if (rsp_id !== 2'd0) $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); else passed++;
        total++; if (alu_control !== '0) $display("FAIL reset_alu_control: got %h want 0", alu_control); else passed++;
        step();
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            #4;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || alu_control !== '0) bad++;
            step();
        end
        total++; if (bad !== 0) $display("FAIL idle_cycles: %0d bad cycles, want 0", bad); else passed++;
    endtask

    task automatic test_single_issue();
        do_reset();
        set_req(1, ADD, 36'd5, 36'd3);
        #4;
        total++; if (req_ready !== 4'b0010) $display("FAIL single_grant: got %b want 0010", req_ready); else passed++;
        total++; if (alu_control !== ADD || alu_A !== 36'd5 || alu_B !== 36'd3)
            $display("FAIL single_alu_fields: ctrl=%h A=%0d B=%0d want %h 5 3", alu_control, alu_A, alu_B, ADD); else passed++;
        step();
        set_req(1, ADD, 36'd1, 36'd1);
        for (int c = 1; c < 4; c++) begin
            #4;
            total++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0)
                $display("FAIL single_pending_t%0d: ready=%b rsp_valid=%b want 0000 0", c, req_ready, rsp_valid); else passed++;
            step();
        end
        #4;
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1)
            $display("FAIL single_rsp: valid=%b id=%0d want 1 1", rsp_valid, rsp_id); else passed++;
        total++; if (rsp_Ra !== 36'd8 || rsp_Rb !== 36'd6)
            $display("FAIL single_rsp_data: Ra=%0d Rb=%0d want 8 6", rsp_Ra, rsp_Rb); else passed++;
        total++; if (req_ready !== 4'b0010 || alu_R !== 36'd8)
            $display("FAIL single_forward: ready=%b R=%0d want 0010 8", req_ready, alu_R); else passed++;
        step();
        clear_inputs();
        repeat (3) step();
        #4;
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_Ra !== 36'd2)
            $display("FAIL single_second_rsp: valid=%b id=%0d Ra=%0d want 1 1 2", rsp_valid, rsp_id, rsp_Ra); else passed++;
        step();
        set_req(1, ADD, 36'd0, 36'd0);
        #4;
        total++; if (alu_R !== 36'd2) $display("FAIL single_r_ctx: got %0d want 2", alu_R); else passed++;
        step();
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] exp_ready;
        logic [W-1:0] exp_r;
        int g;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, ADD, W'(10 * (i + 1)), W'(i));
        for (int c = 0; c < 8; c++) begin
            g = c % N;
            exp_ready = '0;
            exp_ready[g] = 1'b1;
            exp_r = (c < N) ? '0 : W'(10 * (g + 1) + g);
            #4;
            total++; if (req_ready !== exp_ready) $display("FAIL b2b_grant_c%0d: got %b want %b", c, req_ready, exp_ready); else passed++;
            total++; if (alu_R !== exp_r) $display("FAIL b2b_R_c%0d: got %0d want %0d", c, alu_R, exp_r); else passed++;
            if (c >= N) begin
                total++; if (rsp_valid !== 1'b1 || rsp_id !== IDW'(g) || rsp_Ra !== exp_r)
                    $display("FAIL b2b_rsp_c%0d: valid=%b id=%0d Ra=%0d want 1 %0d %0d", c, rsp_valid, rsp_id, rsp_Ra, g, exp_r); else passed++;
            end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_flags();
        do_reset();
        set_req(2, ADD, 36'd7, 36'd0);
        #4;
        total++; if (req_ready !== 4'b0100) $display("FAIL flags_grant: got %b want 0100", req_ready); else passed++;
        step();
        clear_inputs();
        repeat (3) step();
        set_req(2, ADD, 36'hF_FFFF_FFFF, 36'd1);
        #4;
        total++; if (alu_R !== 36'd7 || alu_R_zero !== 1'b0 || alu_R_negative !== 1'b0)
            $display("FAIL flags_fwd7: R=%h z=%b n=%b want 7 0 0", alu_R, alu_R_zero, alu_R_negative); else passed++;
        step();
        clear_inputs();
        repeat (3) step();
        #4;
        total++; if (rsp_Ra !== 36'd0 || rsp_carry_out !== 1'b1 || rsp_overflow !== 1'b0)
            $display("FAIL flags_carry: Ra=%h c=%b v=%b want 0 1 0", rsp_Ra, rsp_carry_out, rsp_overflow); else passed++;
        step();
        set_req(2, ADD, 36'h7_FFFF_FFFF, 36'd1);
        #4;
        total++; if (alu_R !== 36'd0 || alu_R_zero !== 1'b1 || alu_R_negative !== 1'b0)
            $display("FAIL flags_zero: R=%h z=%b n=%b want 0 1 0", alu_R, alu_R_zero, alu_R_negative); else passed++;
        step();
        clear_inputs();
        repeat (3) step();
        set_req(2, ADD, 36'd0, 36'd0);
        #4;
        total++; if (rsp_Ra !== 36'h8_0000_0000 || rsp_overflow !== 1'b1 || rsp_carry_out !== 1'b0)
            $display("FAIL flags_overflow: Ra=%h v=%b c=%b want 800000000 1 0", rsp_Ra, rsp_overflow, rsp_carry_out); else passed++;
        total++; if (alu_R !== 36'h8_0000_0000 || alu_R_negative !== 1'b1 || alu_R_zero !== 1'b0)
            $display("FAIL flags_negative: R=%h n=%b z=%b want 800000000 1 0", alu_R, alu_R_negative, alu_R_zero); else passed++;
        step();
        clear_inputs();
    endtask

    task automatic test_s_write();
        do_reset();
        set_req(3, ADD, 36'd1, 36'd1);
        s_write = 1'b1;
        s_id    = 2'd3;
        s_data  = 36'h123;
        #4;
        total++; if (req_ready !== 4'b1000 || alu_S !== 36'd0)
            $display("FAIL s_old: ready=%b S=%h want 1000 0", req_ready, alu_S); else passed++;
        step();
        clear_inputs();
        repeat (3) step();
        set_req(3, ADD, 36'd2, 36'd2);
        #4;
        total++; if (req_ready !== 4'b1000 || alu_S !== 36'h123)
            $display("FAIL s_new: ready=%b S=%h want 1000 123", req_ready, alu_S); else passed++;
        step();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        int bad;
        do_reset();
        set_req(0, ADD, 36'd9, 36'd9);
        #4;
        total++; if (req_ready !== 4'b0001) $display("FAIL mid_grant: got %b want 0001", req_ready); else passed++;
        step();
        clear_inputs();
        step();
        set_req(0, ADD, 36'd4, 36'd4);
        reset = 1'b1;
        #4;
        total++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0)
            $display("FAIL mid_in_reset: ready=%b rsp_valid=%b want 0000 0", req_ready, rsp_valid); else passed++;
        step();
        reset = 1'b0;
        #4;
        total++; if (req_ready !== 4'b0001) $display("FAIL mid_regrant: got %b want 0001", req_ready); else passed++;
        step();
        clear_inputs();
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            #4;
            if (rsp_valid !== 1'b0) bad++;
            step();
        end
        total++; if (bad !== 0) $display("FAIL mid_discard: %0d stray rsp_valid cycles, want 0", bad); else passed++;
        #4;
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_Ra !== 36'd8)
            $display("FAIL mid_new_rsp: valid=%b id=%0d Ra=%0d want 1 0 8", rsp_valid, rsp_id, rsp_Ra); else passed++;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_single_issue();
        test_back_to_back();
        test_flags();
        test_s_write();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
